fetch_ctrl: RTL

//  Sequencer for the fetch stage. Collapses branch-resolution waits, trap drains and trap-vector

---
 rtl/fetch_ctrl_pkg.sv | 23 ++
 rtl/fetch_ctrl_sat_counter.sv | 25 ++
 rtl/fetch_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch sequencer: PC-select codes, FSM states and default sizes.
// Fetch and the hazard unit import the same package, so encodings cannot drift between them.
package fetch_ctrl_pkg;

  localparam int FC_XLEN       = 64;
  localparam int FC_CNT_W      = 32;
  localparam int FC_BR_TIMEOUT = 15;

  typedef enum logic [1:0] {
    FE_SEL_SEQ    = 2'd0,
    FE_SEL_HOLD   = 2'd1,
    FE_SEL_TARGET = 2'd2,
    FE_SEL_VEC    = 2'd3
  } fe_sel_e;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_BR_WAIT    = 2'd1,
    ST_TRAP_DRAIN = 2'd2,
    ST_REDIRECT   = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear has priority over increment.
module sat_counter #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RESET || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: one FSM covering branch waits, trap drain and trap-vector redirect.
// Every output is a flop; fetch consumes them one edge after the input event that caused them.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int XLEN       = FC_XLEN,
  parameter int CNT_W      = FC_CNT_W,
  parameter int BR_TIMEOUT = FC_BR_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DE_BR_V,
  input  logic             DEP_STALL,
  input  logic             EXE_BR_RES_V,
  input  logic             EXE_BR_TAKEN,
  input  logic [XLEN-1:0]  EXE_BR_TARGET,
  input  logic             TRAP_REQ,
  input  logic             WB_TRAP_COMMIT,
  input  logic [XLEN-1:0]  MT_VEC,
  output logic [1:0]       FE_PC_SEL,
  output logic [XLEN-1:0]  FE_REDIRECT_PC,
  output logic             FE_DE_V,
  output logic             FE_SQUASH,
  output logic [CNT_W-1:0] BUBBLE_CNT,
  output logic             BR_TIMEOUT_ERR,
  output logic [1:0]       CTRL_STATE
);

  localparam int               TMR_W   = $clog2(BR_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(BR_TIMEOUT);

  ctrl_state_e     r_state, w_state_nxt;
  fe_sel_e         r_pc_sel, w_pc_sel_nxt;
  logic [XLEN-1:0] r_redirect_pc, w_redirect_nxt;
  logic            r_de_v, w_de_v_nxt;
  logic            r_squash, w_squash_nxt;
  logic            r_err;
  logic            w_tmr_clr;
  logic [TMR_W-1:0] w_tmr;

  // Priority inside each state: trap, then resolution, then decode branch, then stall.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_sel_nxt   = FE_SEL_HOLD;
    w_redirect_nxt = r_redirect_pc;
    w_de_v_nxt     = 1'b0;
    w_squash_nxt   = 1'b0;
    w_tmr_clr      = (r_state != ST_BR_WAIT);
    case (r_state)
      ST_RUN: begin
        if (TRAP_REQ) begin
          w_state_nxt = ST_TRAP_DRAIN;
        end else if (DE_BR_V && !DEP_STALL) begin
          w_state_nxt = ST_BR_WAIT;
        end else if (DEP_STALL) begin
          w_de_v_nxt = r_de_v;
        end else begin
          w_pc_sel_nxt = FE_SEL_SEQ;
          w_de_v_nxt   = 1'b1;
        end
      end
      ST_BR_WAIT: begin
        if (TRAP_REQ) begin
          w_state_nxt = ST_TRAP_DRAIN;
          w_tmr_clr   = 1'b1;
        end else if (EXE_BR_RES_V) begin
          w_state_nxt = ST_RUN;
          if (EXE_BR_TAKEN) begin
            w_pc_sel_nxt   = FE_SEL_TARGET;
            w_redirect_nxt = EXE_BR_TARGET;
          end else begin
            w_pc_sel_nxt = FE_SEL_SEQ;
          end
        end
      end
      ST_TRAP_DRAIN: begin
        if (WB_TRAP_COMMIT) begin
          w_state_nxt    = ST_REDIRECT;
          w_pc_sel_nxt   = FE_SEL_VEC;
          w_redirect_nxt = MT_VEC;
          w_squash_nxt   = 1'b1;
        end
      end
      ST_REDIRECT: begin
        w_state_nxt  = ST_RUN;
        w_pc_sel_nxt = FE_SEL_SEQ;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // The timeout flag is sticky; it only drops on RESET.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= ST_RUN;
      r_pc_sel      <= FE_SEL_HOLD;
      r_redirect_pc <= '0;
      r_de_v        <= 1'b0;
      r_squash      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc_sel      <= w_pc_sel_nxt;
      r_redirect_pc <= w_redirect_nxt;
      r_de_v        <= w_de_v_nxt;
      r_squash      <= w_squash_nxt;
      r_err         <= r_err | ((r_state == ST_BR_WAIT) && (w_tmr == TMR_MAX));
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .i_clr (1'b0),
    .i_inc (!r_de_v),
    .o_cnt (BUBBLE_CNT)
  );

  sat_counter #(.W(TMR_W), .MAX(TMR_MAX)) u_br_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .i_clr (w_tmr_clr),
    .i_inc (r_state == ST_BR_WAIT),
    .o_cnt (w_tmr)
  );

  assign FE_PC_SEL      = r_pc_sel;
  assign FE_REDIRECT_PC = r_redirect_pc;
  assign FE_DE_V        = r_de_v;
  assign FE_SQUASH      = r_squash;
  assign BR_TIMEOUT_ERR = r_err;
  assign CTRL_STATE     = r_state;

endmodule
